// File: rtl/tetris_input_pkg.sv
// tetris_input_pkg: game command encodings, PS/2 set-2 scan codes and the code-to-command map
package tetris_input_pkg;
  typedef enum logic [2:0] {
    CMD_NONE      = 3'd0,
    CMD_LEFT      = 3'd1,
    CMD_RIGHT     = 3'd2,
    CMD_ROTATE    = 3'd3,
    CMD_SOFT_DROP = 3'd4,
    CMD_HARD_DROP = 3'd5,
    CMD_PAUSE     = 3'd6
  } cmd_e;

  localparam logic [7:0] SC_LEFT      = 8'h6B;
  localparam logic [7:0] SC_RIGHT     = 8'h74;
  localparam logic [7:0] SC_ROTATE    = 8'h75;
  localparam logic [7:0] SC_SOFT_DROP = 8'h72;
  localparam logic [7:0] SC_HARD_DROP = 8'h29;
  localparam logic [7:0] SC_PAUSE     = 8'h4D;

  function automatic cmd_e scan_to_cmd(input logic [7:0] sc);
    return sc == SC_LEFT      ? CMD_LEFT      :
           sc == SC_RIGHT     ? CMD_RIGHT     :
           sc == SC_ROTATE    ? CMD_ROTATE    :
           sc == SC_SOFT_DROP ? CMD_SOFT_DROP :
           sc == SC_HARD_DROP ? CMD_HARD_DROP :
           sc == SC_PAUSE     ? CMD_PAUSE     : CMD_NONE;
  endfunction
endpackage

// File: rtl/cmd_fifo.sv
// cmd_fifo: small FIFO with occupancy counter; a push while full is taken only if a pop frees a slot
module cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 3
) (
  input  logic             CLOCK_50,
  input  logic             resetn,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_pop, do_push;

  always_comb begin
    empty    = count_q == '0;
    full     = count_q == (AW+1)'(DEPTH);
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    mem_d    = mem_q;
    if (do_push) mem_d[wr_ptr_q] = din;
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    dout     = empty ? '0 : mem_q[rd_ptr_q];
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
endmodule

// File: rtl/key_cmd_queue.sv
// key_cmd_queue: maps PS/2 make codes to game commands and queues them; TETRIS_CMD_RATE_LIMIT_EN adds repeat suppression
module key_cmd_queue
  import tetris_input_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int RATE_CYCLES = 2500000
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic [7:0] scan_code,
  input  logic       scan_code_valid,
  output logic [2:0] cmd_data,
  output logic       cmd_valid,
  input  logic       cmd_ready,
  output logic       overflow,
  output logic [7:0] unmapped_cnt
);
  cmd_e       cmd;
  logic       mapped, suppress, push, pop, accept, full, empty;
  logic       overflow_q, overflow_d;
  logic [7:0] unmapped_q, unmapped_d;

  always_comb begin
    cmd        = scan_to_cmd(scan_code);
    mapped     = cmd != CMD_NONE;
    push       = scan_code_valid && mapped && !suppress;
    pop        = cmd_ready && !empty;
    accept     = push && (!full || pop);
    overflow_d = overflow_q || (push && full && !pop);
    unmapped_d = (scan_code_valid && !mapped && unmapped_q != 8'hFF) ? unmapped_q + 8'd1 : unmapped_q;
  end

`ifdef TETRIS_CMD_RATE_LIMIT_EN
  localparam int TW = $clog2(RATE_CYCLES + 1);

  logic [TW-1:0] timer_q, timer_d;
  cmd_e          last_q, last_d;

  // last_q resets to CMD_NONE, which no mapped code matches, so the first command always passes
  always_comb begin
    suppress = (cmd == last_q) && (timer_q != '0);
    timer_d  = accept ? TW'(RATE_CYCLES - 1) : (timer_q != '0 ? timer_q - 1'b1 : timer_q);
    last_d   = accept ? cmd : last_q;
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      timer_q <= '0;
      last_q  <= CMD_NONE;
    end else begin
      timer_q <= timer_d;
      last_q  <= last_d;
    end
  end
`else
  assign suppress = 1'b0;
`endif

  cmd_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(3)) u_fifo (
    .CLOCK_50 (CLOCK_50),
    .resetn   (resetn),
    .push     (push),
    .din      (cmd),
    .pop      (pop),
    .dout     (cmd_data),
    .full     (full),
    .empty    (empty)
  );

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      overflow_q <= 1'b0;
      unmapped_q <= '0;
    end else begin
      overflow_q <= overflow_d;
      unmapped_q <= unmapped_d;
    end
  end

  assign cmd_valid    = !empty;
  assign overflow     = overflow_q;
  assign unmapped_cnt = unmapped_q;
endmodule

// File: tb/tb_key_cmd_queue.sv
// tb_key_cmd_queue: directed self-checking bench for key_cmd_queue
module tb_key_cmd_queue;
  logic       CLOCK_50 = 1'b0;
  logic       resetn = 1'b0;
  logic [7:0] scan_code = '0;
  logic       scan_code_valid = 1'b0;
  logic       cmd_ready = 1'b0;
  logic [2:0] cmd_data;
  logic       cmd_valid, overflow;
  logic [7:0] unmapped_cnt;
  int         checks = 0;
  int         passed = 0;

  key_cmd_queue #(.FIFO_DEPTH(4), .RATE_CYCLES(100)) dut (
    .CLOCK_50        (CLOCK_50),
    .resetn          (resetn),
    .scan_code       (scan_code),
    .scan_code_valid (scan_code_valid),
    .cmd_data        (cmd_data),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .overflow        (overflow),
    .unmapped_cnt    (unmapped_cnt)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  task automatic do_reset();
    @(negedge CLOCK_50);
    resetn = 1'b0;
    scan_code_valid = 1'b0;
    cmd_ready = 1'b0;
    @(negedge CLOCK_50);
    resetn = 1'b1;
  endtask

  task automatic pulse(input logic [7:0] code);
    scan_code = code;
    scan_code_valid = 1'b1;
    @(negedge CLOCK_50);
    scan_code_valid = 1'b0;
  endtask

  task automatic pop_one();
    cmd_ready = 1'b1;
    @(negedge CLOCK_50);
    cmd_ready = 1'b0;
  endtask

  task automatic expect_head(input string name, input logic [2:0] exp);
    checks++;
    if (cmd_valid !== 1'b1 || cmd_data !== exp)
      $display("FAIL %s: valid=%b data=%0d, required valid=1 data=%0d", name, cmd_valid, cmd_data, exp);
    else passed++;
    pop_one();
  endtask

  task automatic expect_empty(input string name);
    checks++;
    if (cmd_valid !== 1'b0 || cmd_data !== 3'd0)
      $display("FAIL %s: valid=%b data=%0d, required valid=0 data=0", name, cmd_valid, cmd_data);
    else passed++;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    #25;
    checks++;
    if ({cmd_valid, cmd_data, overflow, unmapped_cnt} !== 13'd0)
      $display("FAIL reset_outputs: valid=%b data=%0d ovf=%b cnt=%0d, required all 0",
               cmd_valid, cmd_data, overflow, unmapped_cnt);
    else passed++;
    @(negedge CLOCK_50);
    resetn = 1'b1;
    @(negedge CLOCK_50);
  endtask

  task automatic test_single();
    pulse(8'h6B);
    checks++;
    if (cmd_valid !== 1'b1 || cmd_data !== 3'd1)
      $display("FAIL single_latency: valid=%b data=%0d, required valid=1 data=1", cmd_valid, cmd_data);
    else passed++;
    repeat (20) @(negedge CLOCK_50);
    checks++;
    if (cmd_valid !== 1'b1 || cmd_data !== 3'd1)
      $display("FAIL single_hold: valid=%b data=%0d, required valid=1 data=1", cmd_valid, cmd_data);
    else passed++;
    pop_one();
    expect_empty("single_pop");
    pop_one();
    expect_empty("pop_while_empty");
  endtask

  task automatic test_overflow();
    do_reset();
    pulse(8'h74); pulse(8'h75); pulse(8'h72); pulse(8'h29); pulse(8'h4D);
    checks++;
    if (overflow !== 1'b1) $display("FAIL overflow_set: overflow=%b, required 1", overflow);
    else passed++;
    expect_head("ovf_q0", 3'd2);
    expect_head("ovf_q1", 3'd3);
    expect_head("ovf_q2", 3'd4);
    expect_head("ovf_q3", 3'd5);
    expect_empty("ovf_sixth_absent");
    checks++;
    if (overflow !== 1'b1) $display("FAIL overflow_sticky: overflow=%b, required 1", overflow);
    else passed++;
  endtask

  task automatic test_full_pop();
    do_reset();
    pulse(8'h6B); pulse(8'h74); pulse(8'h75); pulse(8'h72);
    cmd_ready = 1'b1;
    pulse(8'h4D);
    cmd_ready = 1'b0;
    checks++;
    if (overflow !== 1'b0) $display("FAIL full_pop_overflow: overflow=%b, required 0", overflow);
    else passed++;
    expect_head("full_pop_q0", 3'd2);
    expect_head("full_pop_q1", 3'd3);
    expect_head("full_pop_q2", 3'd4);
    expect_head("full_pop_q3", 3'd6);
    expect_empty("full_pop_drained");
  endtask

  task automatic test_unmapped();
    do_reset();
    pulse(8'h1C);
    pulse(8'hF0);
    checks++;
    if (unmapped_cnt !== 8'd2) $display("FAIL unmapped_two: cnt=%0d, required 2", unmapped_cnt);
    else passed++;
    for (int i = 0; i < 300; i++) pulse(8'h12);
    checks++;
    if (unmapped_cnt !== 8'd255) $display("FAIL unmapped_sat: cnt=%0d, required 255", unmapped_cnt);
    else passed++;
    expect_empty("unmapped_no_cmd");
  endtask

  task automatic test_rate_limit();
    do_reset();
    for (int t = 0; t <= 150; t++) begin
      scan_code = (t == 60) ? 8'h74 : 8'h6B;
      scan_code_valid = (t == 0 || t == 50 || t == 60 || t == 150);
      @(negedge CLOCK_50);
    end
    scan_code_valid = 1'b0;
`ifdef TETRIS_CMD_RATE_LIMIT_EN
    expect_head("rate_q0", 3'd1);
    expect_head("rate_q1", 3'd2);
    expect_head("rate_q2", 3'd1);
`else
    expect_head("rate_q0", 3'd1);
    expect_head("rate_q1", 3'd1);
    expect_head("rate_q2", 3'd2);
    expect_head("rate_q3", 3'd1);
`endif
    expect_empty("rate_drained");
    checks++;
    if (overflow !== 1'b0) $display("FAIL rate_no_overflow: overflow=%b, required 0", overflow);
    else passed++;
  endtask

  task automatic test_async_reset();
    do_reset();
    pulse(8'h74); pulse(8'h75); pulse(8'h72); pulse(8'h29); pulse(8'h4D);
    pop_one();
    checks++;
    if (cmd_valid !== 1'b1 || overflow !== 1'b1)
      $display("FAIL async_setup: valid=%b ovf=%b, required valid=1 ovf=1", cmd_valid, overflow);
    else passed++;
    #3 resetn = 1'b0;
    #1;
    checks++;
    if ({cmd_valid, cmd_data, overflow, unmapped_cnt} !== 13'd0)
      $display("FAIL async_reset_now: valid=%b data=%0d ovf=%b cnt=%0d, required all 0",
               cmd_valid, cmd_data, overflow, unmapped_cnt);
    else passed++;
    @(negedge CLOCK_50);
    pulse(8'h6B);
    expect_empty("valid_ignored_in_reset");
    resetn = 1'b1;
    @(negedge CLOCK_50);
    pulse(8'h6B);
    expect_head("after_release", 3'd1);
  endtask

  initial begin
    fork
      begin
        #5ms;
        $display("FAIL timeout: run exceeded 5 ms, required completion");
        $fatal(1, "timeout");
      end
    join_none
    test_reset();
    test_single();
    test_overflow();
    test_full_pop();
    test_unmapped();
    test_rate_limit();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
